// File: rtl/viterbi_decoder.sv
// ---------------------------------------------------------------------------
// viterbi_decoder
//
// Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code with
// generators g0 = 111, g1 = 101 (octal 7,5). Four-state add-compare-select
// with register-exchange survivor storage. One symbol is consumed and one
// decoded bit is produced per enabled clock. The decode latency is a fixed
// SURV_LEN enabled cycles. There is no output-valid signal, so the downstream
// block aligns on that latency.
//
// Parameters
//   SURV_LEN  survivor length in bits (= decode latency in enables), 5..64
//   PM_W      path metric width in bits, minimum 4
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   enable  in   d_in carries a valid symbol this cycle
//   d_in    in   [1:0] received symbol, d_in[1] = g0 bit, d_in[0] = g1 bit
//   d_out   out  decoded data bit, registered
//
// Configuration macro
//   VITERBI_BEST_STATE_EN  defined: d_out is taken from the survivor of the
//                          state with the smallest new path metric (lowest
//                          index wins ties). Undefined: d_out is always taken
//                          from the survivor of state 00.
//
// Encoder model (state s = {s1,s0}, s1 = most recent input bit):
//   input b emits {b^s1^s0, b^s0}; next state is {b,s1}; start state is 00.
//
// Handshake: there is no back-pressure. When enable is high, d_in is
// consumed on that rising edge. When enable is low, every register holds.
// ---------------------------------------------------------------------------
module viterbi_decoder #(
  parameter int SURV_LEN = 16,
  parameter int PM_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out
);

  // Start metrics. State 00 is favoured because the encoder is known to
  // start there.
  localparam logic [PM_W-1:0] PM_INIT_ZERO  = '0;
  localparam logic [PM_W-1:0] PM_INIT_OTHER = PM_W'(4);

  // Expected code symbol for input bit b leaving encoder state p.
  function automatic logic [1:0] f_branch_sym(input logic [1:0] p, input logic b);
    f_branch_sym = {b ^ p[1] ^ p[0], b ^ p[0]};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] f_hamming(input logic [1:0] a, input logic [1:0] e);
    logic [1:0] diff;
    diff      = a ^ e;
    f_hamming = {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PM_W-1:0]     r_pm   [4];
  logic [SURV_LEN-1:0] r_surv [4];
  logic                r_dout;

  // -------------------------------------------------------------------------
  // Add-compare-select, one lane per next state
  // -------------------------------------------------------------------------
  logic [PM_W-1:0]     w_cand0    [4];
  logic [PM_W-1:0]     w_cand1    [4];
  logic [PM_W-1:0]     w_pm_acs   [4];
  logic [PM_W-1:0]     w_pm_new   [4];
  logic [SURV_LEN-1:0] w_surv_new [4];
  logic [3:0]          w_sel;
  logic                w_norm;
  logic [1:0]          w_out_state;
  logic                w_dout_next;

  for (genvar g = 0; g < 4; g++) begin : g_acs
    // Next state ns = {b,x}. The decision bit b is its MSB. The two
    // predecessors share x as their most recent bit and differ in the oldest.
    localparam logic [1:0] NS  = 2'(g);
    localparam logic       DEC = NS[1];
    localparam logic [1:0] P0  = {NS[0], 1'b0};
    localparam logic [1:0] P1  = {NS[0], 1'b1};

    logic [1:0] w_bm0;
    logic [1:0] w_bm1;

    assign w_bm0 = f_hamming(d_in, f_branch_sym(P0, DEC));
    assign w_bm1 = f_hamming(d_in, f_branch_sym(P1, DEC));

    // Normalisation keeps every stored metric below the top quarter of the
    // range. The spread between states is small for K=3, so these sums
    // cannot wrap.
    assign w_cand0[g] = r_pm[P0] + PM_W'(w_bm0);
    assign w_cand1[g] = r_pm[P1] + PM_W'(w_bm1);

    // Strictly-less compare: ties go to the p0 predecessor.
    assign w_sel[g]    = (w_cand1[g] < w_cand0[g]);
    assign w_pm_acs[g] = w_sel[g] ? w_cand1[g] : w_cand0[g];

    // Register exchange: inherit the winner's history, shift it left and
    // append this step's decision bit.
    assign w_surv_new[g] = w_sel[g] ? {r_surv[P1][SURV_LEN-2:0], DEC}
                                    : {r_surv[P0][SURV_LEN-2:0], DEC};

    // When every metric has its MSB set, subtracting 2^(PM_W-1) from all of
    // them preserves their differences. That makes it a plain MSB clear.
    assign w_pm_new[g] = w_norm ? {1'b0, w_pm_acs[g][PM_W-2:0]} : w_pm_acs[g];
  end

  assign w_norm = w_pm_acs[0][PM_W-1] & w_pm_acs[1][PM_W-1]
                & w_pm_acs[2][PM_W-1] & w_pm_acs[3][PM_W-1];

  // -------------------------------------------------------------------------
  // Output state selection
  // -------------------------------------------------------------------------
`ifdef VITERBI_BEST_STATE_EN
  logic [PM_W-1:0] w_best_pm;

  // Linear scan with strict compare, so the lowest index wins a tie.
  always_comb begin
    w_best_pm   = w_pm_new[0];
    w_out_state = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (w_pm_new[i] < w_best_pm) begin
        w_best_pm   = w_pm_new[i];
        w_out_state = 2'(i);
      end
    end
  end
`else
  // With a long enough survivor, every path has merged at the oldest bit.
  // So reading from a fixed state gives the same decision without the
  // 4-way comparator.
  assign w_out_state = 2'd0;
`endif

  // The oldest bit of the freshly computed survivor is the decision made
  // SURV_LEN-1 enabled steps ago. Registering it gives a latency of
  // SURV_LEN enables.
  assign w_dout_next = w_surv_new[w_out_state][SURV_LEN-1];

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_pm[i]   <= (i == 0) ? PM_INIT_ZERO : PM_INIT_OTHER;
        r_surv[i] <= '0;
      end
      r_dout <= 1'b0;
    end else if (enable) begin
      for (int i = 0; i < 4; i++) begin
        r_pm[i]   <= w_pm_new[i];
        r_surv[i] <= w_surv_new[i];
      end
      r_dout <= w_dout_next;
    end
  end

  assign d_out = r_dout;

endmodule

// File: tb/tb_viterbi_decoder.sv
// ---------------------------------------------------------------------------
// tb_viterbi_decoder
//
// Self-checking bench for viterbi_decoder. A reference encoder turns source
// bits into code symbols. Each source bit is pushed to exp_q when its symbol
// is driven, and one entry is popped and compared against d_out after every
// enabled edge. After each reset, exp_q is pre-loaded with SURV_LEN-1 zeros,
// which are the cleared-survivor outputs.
// ---------------------------------------------------------------------------
module tb_viterbi_decoder;

  localparam int SURV_LEN = 16;
  localparam int PM_W     = 6;
  localparam int N_SRC    = 256;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] d_in   = 2'b00;
  logic       d_out;

  always #5 clk = ~clk;

  viterbi_decoder #(
    .SURV_LEN(SURV_LEN),
    .PM_W    (PM_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .d_in  (d_in),
    .d_out (d_out)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  logic [0:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] enc_s;
  logic       last_exp;
  logic       src      [N_SRC];
  logic [1:0] err_mask [N_SRC];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_pm_reset();
    check("pm00_reset", 32'(dut.r_pm[0]), 32'd0);
    check("pm01_reset", 32'(dut.r_pm[1]), 32'd4);
    check("pm10_reset", 32'(dut.r_pm[2]), 32'd4);
    check("pm11_reset", 32'(dut.r_pm[3]), 32'd4);
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Assert reset between clock edges. Both the output and the metrics must
  // clear before any rising edge arrives.
  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    check("rst_dout", 32'(d_out), 32'd0);
    check_pm_reset();
    @(negedge clk);
    rst   = 1'b0;
    enc_s = 2'b00;
    exp_q.delete();
    for (int i = 0; i < SURV_LEN - 1; i++) exp_q.push_back(1'b0);
    last_exp = 1'b0;
  endtask

  // Encode one bit, optionally corrupt the symbol, drive it for one enabled
  // cycle and check the output against the scoreboard.
  task automatic send_bit(input logic b, input logic [1:0] mask, input string tag);
    logic [1:0] sym;
    logic [0:0] e;
    sym   = {b ^ enc_s[1] ^ enc_s[0], b ^ enc_s[0]} ^ mask;
    enc_s = {b, enc_s[1]};
    exp_q.push_back(b);
    @(negedge clk);
    d_in   = sym;
    enable = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check(tag, 32'(d_out), 32'hDEAD);
    end else begin
      e        = exp_q.pop_front();
      last_exp = e;
      check(tag, 32'(d_out), 32'(e));
    end
  endtask

  // One cycle with enable low and junk on d_in. The output must hold.
  task automatic idle_cycle(input string tag);
    @(negedge clk);
    enable = 1'b0;
    d_in   = 2'($urandom_range(0, 3));
    @(posedge clk);
    #1;
    check(tag, 32'(d_out), 32'(last_exp));
  endtask

  task automatic send_tail(input string tag);
    for (int i = 0; i < SURV_LEN; i++) send_bit(1'b0, 2'b00, tag);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    enc_s    = 2'b00;
    last_exp = 1'b0;

    // Source stream shared by the error test and the gapped test.
    for (int i = 0; i < N_SRC; i++) begin
      src[i]      = 1'($urandom_range(0, 1));
      err_mask[i] = ((i % 32) == 7) ? 2'($urandom_range(1, 2)) : 2'b00;
    end

    // All-zero stream: output stays 0 and the state-00 metric stays 0.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_bit(1'b0, 2'b00, "zero_dout");
      check("zero_pm00", 32'(dut.r_pm[0]), 32'd0);
    end

    // Impulse: a single 1 must surface on the SURV_LEN-th enabled edge.
    do_reset();
    send_bit(1'b1, 2'b00, "impulse");
    for (int i = 0; i < 30; i++) send_bit(1'b0, 2'b00, "impulse");

    // Random data with one flipped symbol bit every 32 symbols.
    do_reset();
    for (int i = 0; i < N_SRC; i++) send_bit(src[i], err_mask[i], "rand_err");
    send_tail("rand_err_tail");

    // The same stream with 3-cycle enable gaps every 10 symbols.
    do_reset();
    for (int i = 0; i < N_SRC; i++) begin
      if (i > 0 && (i % 10) == 0) begin
        for (int k = 0; k < 3; k++) idle_cycle("gap_hold");
      end
      send_bit(src[i], err_mask[i], "gap_data");
    end
    send_tail("gap_tail");

    // Mid-stream reset, then a fresh stream.
    do_reset();
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)), 2'b00, "pre_rst");
    do_reset();
    for (int i = 0; i < 60; i++) send_bit(1'($urandom_range(0, 1)), 2'b00, "post_rst");
    send_tail("post_rst_tail");

    // Sparse errors (one per 12 symbols) over a long run. The best metric
    // climbs past 2^(PM_W-1), so normalisation has to fire mid-stream.
    do_reset();
    for (int i = 0; i < 480; i++) begin
      send_bit(1'($urandom_range(0, 1)),
               ((i % 12) == 3) ? 2'($urandom_range(1, 2)) : 2'b00, "norm_data");
    end
    send_tail("norm_tail");

    // Alternating data 1010... for 1000 cycles.
    do_reset();
    for (int i = 0; i < 1000; i++) send_bit(((i % 2) == 0) ? 1'b1 : 1'b0, 2'b00, "alt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/viterbi_decoder.md
Name: viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's rate-1/2, constraint-length-3 convolutional code. Generators are g0 = 111 and g1 = 101 (octal 7,5).
- Sits on the receive side of the tx/rx loop. It consumes one registered 2-bit code symbol per enabled clock and emits one decoded data bit per enabled clock after a fixed survivor-path delay.
- Uses 4-state add-compare-select with register-exchange survivor storage.

Parameters:
- SURV_LEN, 16: survivor register length in bits. Equals the decode latency in enabled cycles. Legal range 5..64.
- PM_W, 6: path metric width in bits. Minimum 4.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  d_in carries a valid symbol this cycle.
- d_in  input  2  received symbol; d_in[1] = g0 bit, d_in[0] = g1 bit.
- d_out  output  1  decoded data bit, registered.

Behaviour:
- Encoder model:
  - State s = {s1,s0}; s1 is the most recent input bit.
  - Input b emits {b^s1^s0, b^s0}; next state is {b,s1}.
  - Encoder starts in state 00.
- Branch metric: Hamming distance (0..2) between d_in and the expected symbol of each transition.
- ACS for each next state ns = {b,x}:
  - Predecessors are p0 = {x,0} and p1 = {x,1}.
  - Candidate = PM[p] + BM(p,b).
  - Select the smaller candidate. On a tie, select p0.
- Survivor update: SURV[ns] <= {SURV[sel][SURV_LEN-2:0], b}, i.e. shift left and insert the decision bit at the LSB.
- Output:
  - d_out <= MSB of the newly computed survivor of the output state (see Optional Feature).
  - A data bit whose symbol is consumed on enabled edge n appears on d_out after enabled edge n+SURV_LEN-1, i.e. latency is SURV_LEN enables.
- Metric normalisation: if all four new metrics have the MSB set, clear the MSB of all four in the same update. Metrics never wrap.
- enable low: PM, SURV and d_out all hold. Latency counts enabled cycles only.
- Reset (asynchronous, takes effect immediately, including mid-stream):
  - PM[00] = 0; PM[01], PM[10], PM[11] = 4.
  - All SURV = 0.
  - d_out = 0.
- After reset, the first SURV_LEN-1 d_out values are the cleared-survivor zeros.
- No output valid signal. The downstream block aligns on the fixed latency.
- Error correction: all single isolated symbol-bit errors spaced ≥ 5 symbols apart are corrected (free distance 5). Dense bursts beyond this are not guaranteed.
- Purely synchronous datapath apart from the reset; one ACS step per enabled clock with no multicycle paths.

Optional Feature:
- Macro: VITERBI_BEST_STATE_EN.
- Defined: the output state is the state with the minimum new path metric. Ties resolve to the lowest state index.
- Undefined: the output state is fixed at 00. This saves the 4-way comparator; with the default SURV_LEN=16, results on clean streams are identical.

Test Plan:
- All-zero symbols 00 with enable high for 40 cycles -> d_out = 0 throughout; PM[00] stays 0.
- Impulse: data 1 then zeros, i.e. symbols 11,10,11,00,... -> d_out = 1 for exactly one cycle, on the SURV_LEN-th enabled edge (16), else 0.
- Random 256-bit data through the reference encoder, one flipped bit every 32 symbols -> decoded stream equals the source delayed 16 enables, zero bit errors.
- Same stream with enable deasserted for 3-cycle gaps every 10 symbols -> identical decoded sequence; d_out and metrics hold during gaps.
- Reset asserted mid-stream for 1 cycle -> d_out = 0 immediately and metrics return to 0/4/4/4; after release, a fresh encoded stream decodes correctly.
- Alternating data 1010... -> symbols 11,10,00,10,... -> d_out alternates 1,0 starting at enable 16; no normalisation glitch over 1000 cycles.
